neuron_activation: RTL
======================

Name: neuron_activation

Overview:
- Downstream stage of the dot-product unit. Consumes the FP32 (IEEE-754 single) scalar the dot product produces when its `done` fires.
- Adds a per-neuron FP32 bias, then applies ReLU. Optionally applies leaky ReLU instead.
- Emits one FP32 neuron output with a `done` pulse. Fixed-latency, multi-cycle FSM.
- Many instances (one per neuron) later sit behind a matrix-vector stage.

Parameters:
- LEAK_SHIFT, 3, leaky-ReLU slope as power of two: negative outputs are scaled by 2^-LEAK_SHIFT. Legal range 1..8. Used only when LEAKY_RELU_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- dot_in  in  32  FP32 dot-product result (bit pattern).
- bias  in  32  FP32 bias (bit pattern).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  32  FP32 activated output; held until the next done.

Behaviour:
- Reset: synchronous, active-high, one clock. Forces state=IDLE, busy=0, done=0, result=32'h0. Applies mid-operation too: the in-flight op is aborted and no done is produced.
- Capture: in IDLE with start=1, dot_in and bias are registered. dot_in/bias may change freely afterwards.
- States: IDLE -> ALIGN -> ADD -> NORM -> ACT -> IDLE. One cycle each, no stalls.
  - ACT cycle: result is updated and done=1.
- Latency: start sampled at edge N -> done=1 during cycle N+4, i.e. after 4 further edges. busy=1 over cycles N+1..N+4.
- Back-to-back: start in the cycle after done is accepted (state is IDLE). start while busy is ignored, with no queuing.
- ALIGN:
  - Unpack both operands. Exponent 0 (zero/denormal) is treated as signed zero; denormals are flushed.
  - Swap so operand A has the larger magnitude.
  - Shift B's 24-bit mantissa (hidden 1) right by the exponent difference, keeping 3 extra LSBs: guard, round, sticky. Sticky = OR of all bits shifted out.
  - A difference of 27 or more makes B all-sticky.
- ADD:
  - Equal signs: add magnitudes into a 28-bit sum.
  - Opposite signs: subtract B from A.
  - Result sign is sign(A). An exact zero gives +0.
- NORM:
  - Carry out: shift right 1, exponent+1, preserving sticky.
  - Otherwise: left-shift by the leading-zero count, computed by a combinational priority encoder so the cycle count stays fixed, and decrement the exponent.
  - Then drop G/R/S. Rounding is truncation toward zero; no round-up ever.
  - Exponent >= 255 gives ±Inf (8'hFF, mantissa 0). Exponent <= 0 gives +0.
- Special inputs: either operand with exponent 8'hFF (Inf or NaN) gives result 32'h7FC00000, bypassing activation.
- ACT (ReLU):
  - Sign 0: pass through.
  - Sign 1, including -0 and -Inf: +0 (32'h00000000).

Optional Feature:
- Macro LEAKY_RELU_EN.
- Defined: a negative, non-zero NORM result has its exponent reduced by LEAK_SHIFT.
  - New exponent <= 0 gives -0 (32'h80000000).
  - -Inf stays -Inf (32'hFF800000).
  - -0 becomes +0.
  - Positive path unchanged.
- Undefined: plain ReLU as above. LEAK_SHIFT is unused.
- Latency is identical in both builds.

Test Plan:
- dot_in=32'h40A00000 (5.0), bias=32'hC0000000 (-2.0), start pulse -> done exactly 4 edges later, result=32'h40400000 (3.0), busy high for those 4 cycles.
- dot_in=1.0 (32'h3F800000), bias=-3.0 (32'hC0400000) -> default build result=32'h00000000; LEAKY_RELU_EN with LEAK_SHIFT=3 -> 32'hBE800000 (-0.25).
- dot_in=1.5 (32'h3FC00000), bias=-1.5 (32'hBFC00000) -> result=32'h00000000 (exact cancel, +0); dot_in=32'h4B800000 (2^24), bias=1.0 -> 32'h4B800000 (truncation).
- dot_in=bias=32'h7F7FFFFF -> result=32'h7F800000 (+Inf); dot_in=32'h7FC00001 (NaN), bias=0 -> result=32'h7FC00000.
- Second start asserted 2 cycles into an op -> ignored, exactly one done. Next start the cycle after done -> accepted, done 4 edges later.
- rst=1 for one cycle during NORM -> next cycle busy=0, done=0, result=0, no done pulse. A following start completes normally.

Source files
------------

// File: rtl/neuron_activation.sv
// neuron_activation: adds an FP32 bias to a dot-product result, then applies ReLU, with a fixed latency of 4 cycles.
// Optional macro LEAKY_RELU_EN replaces clamping of negative results with scaling by 2^-LEAK_SHIFT.
module neuron_activation #(
    parameter int LEAK_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dot_in,
    input  logic [31:0] bias,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ACT} state_t;

    state_t      state_q, state_d;
    logic [31:0] dot_q, dot_d, bias_q, bias_d;
    logic        special_q, special_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [7:0]  exp_q, exp_d;
    logic [26:0] opa_q, opa_d, opb_q, opb_d;
    logic [27:0] sum_q, sum_d;
    logic [31:0] result_q, result_d;

    logic        swap;
    logic [31:0] op_a, op_b;
    logic [23:0] man_a, man_b;
    logic [7:0]  exp_diff;
    logic [26:0] b_ext, b_mask, b_shift;

    // Zero and denormal operands compare as magnitude 0.
    always_comb begin
        swap     = ((bias_q[30:23] != 8'd0) ? bias_q[30:0] : 31'd0) >
                   ((dot_q[30:23]  != 8'd0) ? dot_q[30:0]  : 31'd0);
        op_a     = swap ? bias_q : dot_q;
        op_b     = swap ? dot_q  : bias_q;
        man_a    = (op_a[30:23] == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
        man_b    = (op_b[30:23] == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
        exp_diff = op_a[30:23] - op_b[30:23];
        b_ext    = {man_b, 3'b000};
        b_mask   = '0;
        if (exp_diff >= 8'd27) begin
            b_shift = {26'd0, |man_b};
        end else begin
            b_mask  = (27'd1 << exp_diff[4:0]) - 27'd1;
            b_shift = (b_ext >> exp_diff[4:0]) | {26'd0, |(b_ext & b_mask)};
        end
    end

    logic [4:0]        lzc;
    logic [22:0]       frac_n;
    logic signed [9:0] exp_n;
    logic [31:0]       norm_val, act_val;

    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) lzc = 5'(26 - i);
        end
        if (sum_q[27]) begin
            frac_n = sum_q[26:4];
            exp_n  = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            frac_n = 23'((sum_q[26:0] << lzc) >> 3);
            exp_n  = $signed({2'b00, exp_q}) - $signed({5'd0, lzc});
        end
        if (special_q)
            norm_val = 32'h7FC0_0000;
        else if (sum_q == 28'd0 || exp_n <= 10'sd0)
            norm_val = 32'h0000_0000;
        else if (exp_n >= 10'sd255)
            norm_val = {sign_q, 8'hFF, 23'd0};
        else
            norm_val = {sign_q, exp_n[7:0], frac_n};
    end

`ifdef LEAKY_RELU_EN
    localparam logic [7:0] LEAK_EXP = 8'(LEAK_SHIFT);

    always_comb begin
        act_val = norm_val;
        if (!special_q && norm_val[31]) begin
            if (norm_val[30:0] == 31'd0)
                act_val = 32'h0000_0000;
            else if (norm_val[30:23] == 8'hFF)
                act_val = norm_val;
            else if (norm_val[30:23] <= LEAK_EXP)
                act_val = 32'h8000_0000;
            else
                act_val = {1'b1, norm_val[30:23] - LEAK_EXP, norm_val[22:0]};
        end
    end
`else
    always_comb begin
        act_val = norm_val;
        if (!special_q && norm_val[31]) act_val = 32'h0000_0000;
    end
`endif

    always_comb begin
        state_d   = state_q;
        dot_d     = dot_q;
        bias_d    = bias_q;
        special_d = special_q;
        sign_d    = sign_q;
        sub_d     = sub_q;
        exp_d     = exp_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sum_d     = sum_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ALIGN;
                    dot_d   = dot_in;
                    bias_d  = bias;
                end
            end
            ALIGN: begin
                state_d   = ADD;
                special_d = (&dot_q[30:23]) | (&bias_q[30:23]);
                sign_d    = op_a[31];
                sub_d     = op_a[31] ^ op_b[31];
                exp_d     = op_a[30:23];
                opa_d     = {man_a, 3'b000};
                opb_d     = b_shift;
            end
            ADD: begin
                state_d = NORM;
                sum_d   = sub_q ? ({1'b0, opa_q} - {1'b0, opb_q})
                                : ({1'b0, opa_q} + {1'b0, opb_q});
            end
            NORM: begin
                state_d  = ACT;
                result_d = act_val;
            end
            ACT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dot_q     <= '0;
            bias_q    <= '0;
            special_q <= 1'b0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            exp_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            sum_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            dot_q     <= dot_d;
            bias_q    <= bias_d;
            special_q <= special_d;
            sign_q    <= sign_d;
            sub_q     <= sub_d;
            exp_q     <= exp_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sum_q     <= sum_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == ACT);
    assign result = result_q;
endmodule
